dq_latch_write_arbiter: RTL and testbench



---
 rtl/dq_latch_write_arbiter_if.sv | 41 ++++
 rtl/dq_latch_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_dq_latch_write_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dq_latch_write_arbiter_if.sv
// Requester and latch-bank signal bundle for dq_latch_write_arbiter.
// DQ_LATCH_VERIFY_EN adds the latch read-back bus (lat_q) and verify_err.
interface dq_latch_write_arbiter_if #(
    parameter int WIDTH  = 4,
    parameter int NWORDS = 4,
    parameter int AW     = 2
);
    logic [1:0]        req;
    logic [AW-1:0]     addr0;
    logic [WIDTH-1:0]  data0;
    logic [AW-1:0]     addr1;
    logic [WIDTH-1:0]  data1;
    logic [1:0]        gnt;
    logic [1:0]        ack;
    logic              addr_err;
    logic              busy;
    logic [WIDTH-1:0]  lat_d;
    logic [NWORDS-1:0] lat_en;
`ifdef DQ_LATCH_VERIFY_EN
    logic [NWORDS*WIDTH-1:0] lat_q;
    logic                    verify_err;

    modport master (
        output req, addr0, data0, addr1, data1, lat_q,
        input  gnt, ack, addr_err, busy, lat_d, lat_en, verify_err
    );
    modport slave (
        input  req, addr0, data0, addr1, data1, lat_q,
        output gnt, ack, addr_err, busy, lat_d, lat_en, verify_err
    );
`else
    modport master (
        output req, addr0, data0, addr1, data1,
        input  gnt, ack, addr_err, busy, lat_d, lat_en
    );
    modport slave (
        input  req, addr0, data0, addr1, data1,
        output gnt, ack, addr_err, busy, lat_d, lat_en
    );
`endif
endinterface

// File: rtl/dq_latch_write_arbiter.sv
// Round-robin write arbiter driving a bank of transparent DQ latches with a setup/strobe/hold sequence.
// Optional read-back compare of the written word is enabled by DQ_LATCH_VERIFY_EN.
module dq_latch_write_arbiter #(
    parameter int WIDTH     = 4,
    parameter int NWORDS    = 4,
    parameter int AW        = 2,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dq_latch_write_arbiter_if.slave  bus
);
    localparam int CMAX = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        ack_q, ack_d;
    logic              addr_err_q, addr_err_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  lat_d_q, lat_d_d;
    logic [NWORDS-1:0] lat_en_q, lat_en_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              rr_last_q, rr_last_d;

    logic              in_range;
    logic              win1;
    logic [NWORDS-1:0] en_dec;

    assign in_range = int'(addr_q) < NWORDS;
    // On a tie the requester that did not win last time takes the bank.
    assign win1     = bus.req[1] & (~bus.req[0] | ~rr_last_q);

    always_comb begin
        en_dec = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (addr_q == AW'(i)) en_dec[i] = 1'b1;
        end
    end

`ifdef DQ_LATCH_VERIFY_EN
    logic             verify_err_q, verify_err_d;
    logic [WIDTH-1:0] q_word;

    always_comb begin
        q_word = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (addr_q == AW'(i)) q_word = bus.lat_q[i*WIDTH +: WIDTH];
        end
    end
`endif

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        ack_d      = 2'b00;
        addr_err_d = 1'b0;
        lat_d_d    = lat_d_q;
        lat_en_d   = '0;
        addr_d     = addr_q;
        rr_last_d  = rr_last_q;
`ifdef DQ_LATCH_VERIFY_EN
        verify_err_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    gnt_d     = win1 ? 2'b10 : 2'b01;
                    addr_d    = win1 ? bus.addr1 : bus.addr0;
                    lat_d_d   = win1 ? bus.data1 : bus.data0;
                    rr_last_d = win1;
                    cnt_d     = SETUP_LD;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    lat_en_d = en_dec;
                    cnt_d    = EN_LD;
                    state_d  = S_STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    ack_d      = gnt_q;
                    addr_err_d = ~in_range;
`ifdef DQ_LATCH_VERIFY_EN
                    // Latch is still transparent here, so this is its settled HOLD-cycle value.
                    verify_err_d = in_range && (q_word != lat_d_q);
`endif
                    state_d    = S_HOLD;
                end else begin
                    lat_en_d = en_dec;
                    cnt_d    = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            gnt_q      <= 2'b00;
            ack_q      <= 2'b00;
            addr_err_q <= 1'b0;
            busy_q     <= 1'b0;
            lat_d_q    <= '0;
            lat_en_q   <= '0;
            addr_q     <= '0;
            rr_last_q  <= 1'b1;
`ifdef DQ_LATCH_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            addr_err_q <= addr_err_d;
            busy_q     <= busy_d;
            lat_d_q    <= lat_d_d;
            lat_en_q   <= lat_en_d;
            addr_q     <= addr_d;
            rr_last_q  <= rr_last_d;
`ifdef DQ_LATCH_VERIFY_EN
            verify_err_q <= verify_err_d;
`endif
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.addr_err = addr_err_q;
    assign bus.busy     = busy_q;
    assign bus.lat_d    = lat_d_q;
    assign bus.lat_en   = lat_en_q;
`ifdef DQ_LATCH_VERIFY_EN
    assign bus.verify_err = verify_err_q;
`endif
endmodule

// File: tb/tb_dq_latch_write_arbiter.sv
// Self-checking bench: instance A uses default parameters, instance B uses NWORDS=3, SETUP_CYC=2, EN_CYC=3.
// Build with DQ_LATCH_VERIFY_EN to also exercise the read-back compare.
module tb_dq_latch_write_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dq_latch_write_arbiter_if #(.WIDTH(4), .NWORDS(4), .AW(2)) bus_a ();
    dq_latch_write_arbiter_if #(.WIDTH(4), .NWORDS(3), .AW(2)) bus_b ();

    dq_latch_write_arbiter #(.WIDTH(4), .NWORDS(4), .AW(2), .SETUP_CYC(1), .EN_CYC(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    dq_latch_write_arbiter #(.WIDTH(4), .NWORDS(3), .AW(2), .SETUP_CYC(2), .EN_CYC(3)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    logic stuck = 1'b0;
`ifdef DQ_LATCH_VERIFY_EN
    // Behavioural transparent latches; "stuck" pins bit 0 of every word of bank A at 0.
    always @* begin
        for (int i = 0; i < 4; i++)
            if (bus_a.lat_en[i]) bus_a.lat_q[i*4 +: 4] = bus_a.lat_d & {3'b111, ~stuck};
    end
    always @* begin
        for (int i = 0; i < 3; i++)
            if (bus_b.lat_en[i]) bus_b.lat_q[i*4 +: 4] = bus_b.lat_d;
    end
`endif

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] ack;
        logic       addr_err;
        logic       busy;
        logic       verr;
        logic [3:0] lat_d;
        logic [3:0] lat_en;
    } snap_t;

    typedef struct {
        bit         rst;
        bit         b;
        logic [1:0] req;
        logic [1:0] a0;
        logic [3:0] d0;
        logic [1:0] a1;
        logic [3:0] d1;
        int         exp_w;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int rr_m [2];
    logic [3:0] last_d [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic snap_t snap(input bit b);
        snap_t s;
        s = '0;
        if (b) begin
            s.gnt = bus_b.gnt; s.ack = bus_b.ack; s.addr_err = bus_b.addr_err;
            s.busy = bus_b.busy; s.lat_d = bus_b.lat_d; s.lat_en = {1'b0, bus_b.lat_en};
`ifdef DQ_LATCH_VERIFY_EN
            s.verr = bus_b.verify_err;
`endif
        end else begin
            s.gnt = bus_a.gnt; s.ack = bus_a.ack; s.addr_err = bus_a.addr_err;
            s.busy = bus_a.busy; s.lat_d = bus_a.lat_d; s.lat_en = bus_a.lat_en;
`ifdef DQ_LATCH_VERIFY_EN
            s.verr = bus_a.verify_err;
`endif
        end
        return s;
    endfunction

    task automatic drive(input bit b, input logic [1:0] req, input logic [1:0] a0, input logic [3:0] d0,
                         input logic [1:0] a1, input logic [3:0] d1);
        if (b) begin
            bus_b.req = req; bus_b.addr0 = a0; bus_b.data0 = d0; bus_b.addr1 = a1; bus_b.data1 = d1;
        end else begin
            bus_a.req = req; bus_a.addr0 = a0; bus_a.data0 = d0; bus_a.addr1 = a1; bus_a.data1 = d1;
        end
    endtask

    function automatic int pick(input bit b, input logic [1:0] req);
        if (req == 2'b11) return 1 - rr_m[b];
        return req[1] ? 1 : 0;
    endfunction

    // Reference timeline of one write: S setup cycles, E strobe cycles, one hold cycle, then idle.
    task automatic txn(input bit b, input logic [1:0] req, input logic [1:0] a0, input logic [3:0] d0,
                       input logic [1:0] a1, input logic [3:0] d1, input int exp_w, input bit scramble,
                       input string tag);
        logic [1:0] a;
        logic [3:0] d;
        int s, e, n;
        snap_t ex;
        a = (exp_w == 1) ? a1 : a0;
        d = (exp_w == 1) ? d1 : d0;
        s = b ? 2 : 1;
        e = b ? 3 : 1;
        n = b ? 3 : 4;
        drive(!b, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0);
        drive(b, req, a0, d0, a1, d1);
        @(posedge clk);
        for (int t = 0; t <= s + e + 1; t++) begin
            @(negedge clk);
            ex = '0;
            ex.lat_d = d;
            if (t <= s + e) begin
                ex.gnt  = (exp_w == 1) ? 2'b10 : 2'b01;
                ex.busy = 1'b1;
            end
            if (t >= s && t < s + e && int'(a) < n) ex.lat_en = 4'b0001 << a;
            if (t == s + e) begin
                ex.ack      = ex.gnt;
                ex.addr_err = (int'(a) >= n);
`ifdef DQ_LATCH_VERIFY_EN
                ex.verr = !b && stuck && d[0] && (int'(a) < n);
`endif
            end
            check($sformatf("%s t%0d", tag, t), 32'(snap(b)), 32'(ex));
            if (scramble && t < s + e)
                drive(b, 2'($urandom), 2'($urandom), 4'($urandom), 2'($urandom), 4'($urandom));
        end
        rr_m[b]   = exp_w;
        last_d[b] = d;
    endtask

    task automatic idle(input bit b, input int cycles);
        snap_t ex;
        drive(0, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0);
        drive(1, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            ex = '0;
            ex.lat_d = last_d[b];
            check($sformatf("idle%0d i%0d", b, i), 32'(snap(b)), 32'(ex));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0);
        drive(1, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0);
        repeat (2) @(negedge clk);
        check("reset A", 32'(snap(0)), 32'd0);
        check("reset B", 32'(snap(1)), 32'd0);
        rst_n = 1'b1;
        rr_m[0] = 1; rr_m[1] = 1;
        last_d[0] = 4'd0; last_d[1] = 4'd0;
    endtask

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 2'b01, 2'd2, 4'hA, 2'd0, 4'h0, 0};
        tbl[1] = '{1'b1, 1'b0, 2'b11, 2'd1, 4'h3, 2'd0, 4'h5, 0};
        tbl[2] = '{1'b0, 1'b0, 2'b11, 2'd1, 4'h3, 2'd0, 4'h5, 1};
        tbl[3] = '{1'b0, 1'b0, 2'b11, 2'd3, 4'hC, 2'd2, 4'h9, 0};
        tbl[4] = '{1'b0, 1'b0, 2'b11, 2'd3, 4'hC, 2'd2, 4'h9, 1};
        tbl[5] = '{1'b0, 1'b1, 2'b10, 2'd0, 4'h0, 2'd3, 4'hF, 1};
        tbl[6] = '{1'b0, 1'b1, 2'b01, 2'd0, 4'h6, 2'd1, 4'h2, 0};
        tbl[7] = '{1'b0, 1'b0, 2'b10, 2'd0, 4'h4, 2'd3, 4'h7, 1};
        tbl[8] = '{1'b0, 1'b1, 2'b11, 2'd2, 4'h1, 2'd1, 4'h8, 1};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst) begin
                idle(tbl[i].b, 1);
                do_reset();
            end
            txn(tbl[i].b, tbl[i].req, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1,
                tbl[i].exp_w, 1'b0, $sformatf("vec%0d", i));
        end
        idle(0, 2);

        // Asynchronous reset while bank A is strobing word 1.
        drive(0, 2'b01, 2'd1, 4'h5, 2'd0, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid strobe lat_en", 32'(bus_a.lat_en), 32'h2);
        rst_n = 1'b0;
        #1;
        check("async lat_en", 32'(bus_a.lat_en), 32'h0);
        check("async busy", 32'(bus_a.busy), 32'h0);
        drive(0, 2'b00, 2'd0, 4'd0, 2'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        check("no ack in reset", 32'(snap(0)), 32'd0);
        rst_n = 1'b1;
        rr_m[0] = 1; rr_m[1] = 1;
        last_d[0] = 4'd0; last_d[1] = 4'd0;
        txn(0, 2'b11, 2'd0, 4'h9, 2'd3, 4'h6, 0, 1'b0, "post reset");

        // Randomized writes against the timeline model, with request lines scrambled mid-write.
        for (int i = 0; i < 60; i++) begin
            bit b;
            logic [1:0] req;
            b   = 1'($urandom);
            req = 2'($urandom_range(1, 3));
            txn(b, req, 2'($urandom), 4'($urandom), 2'($urandom), 4'($urandom),
                pick(b, req), 1'b1, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0) idle(b, $urandom_range(1, 3));
        end
        idle(0, 1);

`ifdef DQ_LATCH_VERIFY_EN
        stuck = 1'b1;
        txn(0, 2'b01, 2'd1, 4'hF, 2'd0, 4'h0, 0, 1'b0, "stuck");
        idle(0, 1);
        stuck = 1'b0;
        for (int v = 0; v < 16; v++) begin
            txn(0, 2'b01, 2'(v), 4'(v), 2'd0, 4'h0, 0, 1'b0, $sformatf("verify%0d", v));
            idle(0, 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
